// File: rtl/udp_reg_ring_master.sv
// Head-end initiator of the register ring: launches one CPU access per request and completes it on return, unclaimed or timeout.
// Ack follows the sampled return by one cycle; CPU requests are ignored while busy, with no queuing.
module udp_reg_ring_master #(
    parameter int                    ADDR_WIDTH     = 23,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    SRC_WIDTH      = 2,
    parameter int                    SRC_ID         = 0,
    parameter int                    TIMEOUT_CYCLES = 127,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  core_reg_req,
    input  logic                  core_reg_rd_wr_L,
    input  logic [ADDR_WIDTH-1:0] core_reg_addr,
    input  logic [DATA_WIDTH-1:0] core_reg_wr_data,
    output logic                  core_reg_ack,
    output logic [DATA_WIDTH-1:0] core_reg_rd_data,
    output logic [1:0]            core_reg_err,
    output logic                  core_reg_busy,

    output logic                  reg_req_out,
    output logic                  reg_ack_out,
    output logic                  reg_rd_wr_L_out,
    output logic [ADDR_WIDTH-1:0] reg_addr_out,
    output logic [DATA_WIDTH-1:0] reg_data_out,
    output logic [SRC_WIDTH-1:0]  reg_src_out,

    input  logic                  reg_req_in,
    input  logic                  reg_ack_in,
    input  logic                  reg_rd_wr_L_in,
    input  logic [ADDR_WIDTH-1:0] reg_addr_in,
    input  logic [DATA_WIDTH-1:0] reg_data_in,
    input  logic [SRC_WIDTH-1:0]  reg_src_in
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [SRC_WIDTH-1:0] SRC_VAL  = SRC_ID[SRC_WIDTH-1:0];
    localparam logic [15:0]          TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    logic [15:0]             wait_cnt;
    logic                    lat_rd_wr_L;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic                    ret_match;

    // Only our own request, unchanged in address and direction, counts as the return.
    assign ret_match = reg_req_in && (reg_src_in == SRC_VAL) &&
                       (reg_addr_in == lat_addr) && (reg_rd_wr_L_in == lat_rd_wr_L);

    assign core_reg_busy = (state == WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            wait_cnt         <= '0;
            lat_rd_wr_L      <= 1'b0;
            lat_addr         <= '0;
            core_reg_ack     <= 1'b0;
            core_reg_rd_data <= '0;
            core_reg_err     <= 2'd0;
            reg_req_out      <= 1'b0;
            reg_ack_out      <= 1'b0;
            reg_rd_wr_L_out  <= 1'b0;
            reg_addr_out     <= '0;
            reg_data_out     <= '0;
            reg_src_out      <= '0;
        end else begin
            // Ring outputs and ack default low so each is a single-cycle pulse.
            core_reg_ack    <= 1'b0;
            reg_req_out     <= 1'b0;
            reg_ack_out     <= 1'b0;
            reg_rd_wr_L_out <= 1'b0;
            reg_addr_out    <= '0;
            reg_data_out    <= '0;
            reg_src_out     <= '0;

            case (state)
                IDLE: begin
                    if (core_reg_req) begin
                        state           <= WAIT;
                        wait_cnt        <= '0;
                        lat_rd_wr_L     <= core_reg_rd_wr_L;
                        lat_addr        <= core_reg_addr;
                        reg_req_out     <= 1'b1;
                        reg_rd_wr_L_out <= core_reg_rd_wr_L;
                        reg_addr_out    <= core_reg_addr;
                        reg_data_out    <= core_reg_rd_wr_L ? '0 : core_reg_wr_data;
                        reg_src_out     <= SRC_VAL;
                    end
                end
                WAIT: begin
                    if (ret_match) begin
                        state        <= IDLE;
                        core_reg_ack <= 1'b1;
                        core_reg_err <= reg_ack_in ? 2'd0 : 2'd1;
                        if (!lat_rd_wr_L)
                            core_reg_rd_data <= '0;
                        else
                            core_reg_rd_data <= reg_ack_in ? reg_data_in : ERR_DATA;
                    end else if (wait_cnt == TMO_LAST) begin
                        state            <= IDLE;
                        core_reg_ack     <= 1'b1;
                        core_reg_err     <= 2'd2;
                        core_reg_rd_data <= lat_rd_wr_L ? ERR_DATA : '0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_reg_ring_master.sv
// Randomized bench for udp_reg_ring_master: a behavioural ring responder with per-transaction delay, checked against expected completion timing and status.
module tb_udp_reg_ring_master;

    localparam int          AW   = 23;
    localparam int          DW   = 32;
    localparam int          SW   = 2;
    localparam int          TMO  = 16;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
    localparam int          NEVER = 1000;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_reg_req, core_reg_rd_wr_L;
    logic [AW-1:0] core_reg_addr;
    logic [DW-1:0] core_reg_wr_data;
    logic          core_reg_ack;
    logic [DW-1:0] core_reg_rd_data;
    logic [1:0]    core_reg_err;
    logic          core_reg_busy;
    logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
    logic [AW-1:0] reg_addr_out;
    logic [DW-1:0] reg_data_out;
    logic [SW-1:0] reg_src_out;
    logic          reg_req_in, reg_ack_in, reg_rd_wr_L_in;
    logic [AW-1:0] reg_addr_in;
    logic [DW-1:0] reg_data_in;
    logic [SW-1:0] reg_src_in;

    int tests  = 0;
    int errors = 0;
    logic [1:0]    prev_err = 2'd0;
    logic [DW-1:0] prev_rd  = '0;

    udp_reg_ring_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRC_WIDTH(SW), .SRC_ID(0),
        .TIMEOUT_CYCLES(TMO), .ERR_DATA(ERRD)
    ) dut (
        .clk(clk), .reset(reset),
        .core_reg_req(core_reg_req), .core_reg_rd_wr_L(core_reg_rd_wr_L),
        .core_reg_addr(core_reg_addr), .core_reg_wr_data(core_reg_wr_data),
        .core_reg_ack(core_reg_ack), .core_reg_rd_data(core_reg_rd_data),
        .core_reg_err(core_reg_err), .core_reg_busy(core_reg_busy),
        .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out),
        .reg_rd_wr_L_out(reg_rd_wr_L_out), .reg_addr_out(reg_addr_out),
        .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
        .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in),
        .reg_rd_wr_L_in(reg_rd_wr_L_in), .reg_addr_in(reg_addr_in),
        .reg_data_in(reg_data_in), .reg_src_in(reg_src_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ring_idle();
        reg_req_in = 0; reg_ack_in = 0; reg_rd_wr_L_in = 0;
        reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
    endtask

    // Reference: a return present d cycles after the launch cycle (d=0 is the launch
    // cycle itself) is seen d+1 cycles after reg_req_out, unless the timeout at TMO comes first.
    function automatic bit ret_in_time(input int d);
        return d <= TMO - 1;
    endfunction

    function automatic int model_lat(input int d);
        return ret_in_time(d) ? d + 1 : TMO;
    endfunction

    function automatic logic [1:0] model_err(input int d, input bit ack);
        if (!ret_in_time(d)) return 2'd2;
        return ack ? 2'd0 : 2'd1;
    endfunction

    function automatic logic [DW-1:0] model_rd(input bit rd, input logic [1:0] err, input logic [DW-1:0] rdat);
        if (!rd) return '0;
        return (err == 2'd0) ? rdat : ERRD;
    endfunction

    // Called at posedge+1; issues one CPU access and follows it to completion.
    task automatic do_txn(input bit rd, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int d, input bit ack, input logic [DW-1:0] rdat, input bit junk);
        int lat, extra, sel;
        logic [1:0] e_err;
        core_reg_req = 1; core_reg_rd_wr_L = rd; core_reg_addr = addr; core_reg_wr_data = wd;
        @(posedge clk); #1;
        core_reg_req = 0; core_reg_addr = AW'($urandom); core_reg_wr_data = $urandom;
        core_reg_rd_wr_L = ~rd;
        chk("launch_req", reg_req_out, 1);
        chk("launch_ack_out", reg_ack_out, 0);
        chk("launch_rdwr", reg_rd_wr_L_out, rd);
        chk("launch_addr", reg_addr_out, addr);
        chk("launch_src", reg_src_out, 0);
        chk("launch_data", reg_data_out, rd ? '0 : wd);
        chk("launch_busy", core_reg_busy, 1);
        chk("ack_single_pulse", core_reg_ack, 0);
        chk("err_hold", core_reg_err, prev_err);
        chk("rd_hold", core_reg_rd_data, prev_rd);
        lat = -1; extra = 0;
        for (int c = 0; c < TMO + 4 && lat < 0; c++) begin
            if (c > 0 && reg_req_out) extra++;
            ring_idle();
            if (c == d) begin
                reg_req_in = 1; reg_ack_in = ack; reg_rd_wr_L_in = rd;
                reg_addr_in = addr; reg_data_in = rdat; reg_src_in = 0;
            end else if (junk && (c % 2 == 1)) begin
                sel = $urandom_range(0, 2);
                reg_req_in = 1; reg_ack_in = 1; reg_data_in = $urandom;
                reg_src_in = (sel == 0) ? 2'd1 : 2'd0;
                reg_addr_in = (sel == 1) ? (addr ^ 23'd1) : addr;
                reg_rd_wr_L_in = (sel == 2) ? ~rd : rd;
            end
            if (junk) begin
                core_reg_req = 1'($urandom_range(0, 1));
                core_reg_addr = AW'($urandom);
            end
            @(posedge clk); #1;
            if (core_reg_ack) lat = c + 1;
        end
        ring_idle();
        core_reg_req = 0;
        if (reg_req_out) extra++;
        e_err = model_err(d, ack);
        chk("ack_latency", lat, model_lat(d));
        chk("cpl_err", core_reg_err, e_err);
        chk("cpl_rd_data", core_reg_rd_data, model_rd(rd, e_err, rdat));
        chk("busy_in_ack", core_reg_busy, 0);
        chk("no_extra_launch", extra, 0);
        prev_err = e_err;
        prev_rd  = model_rd(rd, e_err, rdat);
    endtask

    initial begin
        int n_ack;
        reset = 1;
        core_reg_req = 0; core_reg_rd_wr_L = 0; core_reg_addr = '0; core_reg_wr_data = '0;
        ring_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_core", {core_reg_ack, core_reg_err, core_reg_rd_data, core_reg_busy}, 0);
        chk("rst_ring", {reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out}, 0);
        reset = 0;
        @(posedge clk); #1;

        do_txn(1, 23'h000104, 32'h0, 3, 1, 32'h12345678, 0);
        do_txn(0, 23'h000200, 32'hA5A5A5A5, 0, 0, 32'h0, 0);
        do_txn(1, 23'h000300, 32'h0, NEVER, 1, 32'h0, 0);
        do_txn(1, 23'h003ABC, 32'h0, 8, 1, 32'hCAFEF00D, 1);
        // Return on the last permissible edge, then a request during its ack cycle.
        do_txn(1, 23'h000444, 32'h0, TMO - 1, 1, 32'h0BADC0DE, 0);
        do_txn(0, 23'h000448, 32'h11223344, 2, 1, 32'hFFFFFFFF, 0);

        // Asynchronous reset in the middle of WAIT.
        core_reg_req = 1; core_reg_rd_wr_L = 1; core_reg_addr = 23'h000500;
        @(posedge clk); #1;
        core_reg_req = 0;
        repeat (3) @(posedge clk);
        #3 reset = 1;
        #1;
        chk("async_rst_core", {core_reg_ack, core_reg_err, core_reg_rd_data, core_reg_busy}, 0);
        chk("async_rst_ring", {reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out}, 0);
        @(posedge clk); #2 reset = 0;
        n_ack = 0;
        for (int c = 0; c < TMO + 4; c++) begin
            @(posedge clk); #1;
            if (core_reg_ack || core_reg_busy) n_ack++;
        end
        chk("no_ack_after_reset", n_ack, 0);
        prev_err = 2'd0; prev_rd = '0;
        do_txn(1, 23'h000500, 32'h0, 1, 1, 32'h5A5A0001, 0);

        for (int i = 0; i < 25; i++) begin
            bit rd, ack, junk;
            int d;
            rd   = 1'($urandom_range(0, 1));
            ack  = 1'($urandom_range(0, 1));
            junk = 1'($urandom_range(0, 1));
            d    = $urandom_range(0, TMO + 3);
            do_txn(rd, AW'($urandom), $urandom, d, ack, $urandom, junk);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
